axi_bridge: RTL and testbench

Converts the cache-side request interface (rd_req/ret_* for refills and uncached reads, wr_req for dirty-line writebacks and uncached writes) into AXI4 master transactions on a 32-bit bus. Sits directly downstream of the uncache/refill block and upstream of the SoC interconnect. Supports one outstanding read and one outstanding write concurrently, serialising 128-bit lines into 4-beat INCR bursts and collecting read beats back as 32-bit returns.

---
 rtl/axi_bridge_pkg.sv | 32 +++
 rtl/axi_bridge_wr_serializer.sv | 45 ++++
 rtl/axi_bridge.sv | 178 +++++++++++++++++
 tb/tb_axi_bridge.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared encodings for the cache-to-AXI4 bridge: request types, AXI constants
// and the read/write FSM state types.
package axi_bridge_pkg;

  localparam logic [2:0] TYPE_LINE  = 3'b100;
  localparam logic [2:0] TYPE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] RD_ID      = 4'd0;
  localparam logic [3:0] WR_ID      = 4'd1;
  localparam logic [7:0] LEN_LINE   = 8'd3;
  localparam logic [7:0] LEN_WORD   = 8'd0;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Line requests start on a 16-byte boundary; word requests keep their address.
  function automatic logic [31:0] align_addr(input logic [2:0] typ, input logic [31:0] addr);
    return (typ == TYPE_LINE) ? {addr[31:4], 4'h0} : addr;
  endfunction

endpackage

// File: rtl/axi_bridge_wr_serializer.sv
// Holds a write request's 128-bit payload and presents it as 32-bit W beats,
// shifting one word out per accepted beat and flagging the final beat.
module axi_bridge_wr_serializer
  import axi_bridge_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [2:0]   typ,
  input  logic [3:0]   strb,
  input  logic [127:0] data,
  input  logic         adv,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast
);

  logic [127:0] buf_r;
  logic [1:0]   cnt_r;
  logic [3:0]   strb_r;

  // Payload buffer and remaining-beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_r  <= 128'd0;
      cnt_r  <= 2'd0;
      strb_r <= 4'd0;
    end else if (load) begin
      buf_r  <= data;
      cnt_r  <= (typ == TYPE_LINE) ? 2'd3 : 2'd0;
      strb_r <= (typ == TYPE_LINE) ? 4'hF : strb;
    end else if (adv) begin
      buf_r  <= {32'd0, buf_r[127:32]};
      cnt_r  <= (cnt_r == 2'd0) ? 2'd0 : cnt_r - 2'd1;
    end else begin
      buf_r  <= buf_r;
      cnt_r  <= cnt_r;
    end
  end

  assign wdata = buf_r[31:0];
  assign wstrb = strb_r;
  assign wlast = (cnt_r == 2'd0);

endmodule

// File: rtl/axi_bridge.sv
// Cache-side refill/writeback requests to AXI4 master: one outstanding read and
// one outstanding write, 4-beat INCR bursts for lines, single beats for words.
module axi_bridge
  import axi_bridge_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         bus_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  rd_state_t   rd_state_r;
  wr_state_t   wr_state_r;
  logic        run_r;
  logic [31:0] rd_addr_r;
  logic [7:0]  rd_len_r;
  logic [31:0] wr_addr_r;
  logic [7:0]  wr_len_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic        bus_err_r;
  logic        rd_accept_s;
  logic        wr_accept_s;
  logic        wr_hazard_s;
  logic        aw_hs_s;
  logic        w_hs_s;
  logic        unused_s;

  assign unused_s = ^{rid, bid};

  // A read may not overtake a writeback of the same line, pending or starting now.
  assign wr_accept_s = wr_req && wr_rdy;
  assign wr_hazard_s = ((wr_state_r != W_IDLE) && (wr_addr_r[31:4] == rd_addr[31:4])) ||
                       (wr_accept_s && (wr_addr[31:4] == rd_addr[31:4]));
  assign wr_rdy      = run_r && (wr_state_r == W_IDLE);
  assign rd_rdy      = run_r && (rd_state_r == R_IDLE) && !wr_hazard_s;
  assign rd_accept_s = rd_req && rd_rdy;

  assign arid    = RD_ID;
  assign araddr  = rd_addr_r;
  assign arlen   = rd_len_r;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arvalid = (rd_state_r == R_AR);
  assign rready  = (rd_state_r == R_DATA);

  assign ret_valid = rready && rvalid;
  assign ret_last  = rready && rlast;
  assign ret_data  = rdata;

  assign awid    = WR_ID;
  assign awaddr  = wr_addr_r;
  assign awlen   = wr_len_r;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign awvalid = (wr_state_r == W_ADDR) && !aw_done_r;
  assign wvalid  = (wr_state_r == W_ADDR) && !w_done_r;
  assign bready  = (wr_state_r == W_RESP);
  assign aw_hs_s = awvalid && awready;
  assign w_hs_s  = wvalid && wready;
  assign bus_err = bus_err_r;

  axi_bridge_wr_serializer u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (wr_accept_s),
    .typ   (wr_type),
    .strb  (wr_wstrb),
    .data  (wr_data),
    .adv   (w_hs_s),
    .wdata (wdata),
    .wstrb (wstrb),
    .wlast (wlast)
  );

  // Read FSM: AR handshake then pass R beats straight through to the cache.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_r <= R_IDLE;
      rd_addr_r  <= 32'd0;
      rd_len_r   <= 8'd0;
    end else begin
      case (rd_state_r)
        R_IDLE: if (rd_accept_s) begin
          rd_addr_r  <= align_addr(rd_type, rd_addr);
          rd_len_r   <= (rd_type == TYPE_LINE) ? LEN_LINE : LEN_WORD;
          rd_state_r <= R_AR;
        end
        R_AR:   if (arready) rd_state_r <= R_DATA;
        R_DATA: if (rvalid && rlast) rd_state_r <= R_IDLE;
        default: rd_state_r <= R_IDLE;
      endcase
    end
  end

  // Write FSM: AW and W complete independently, then wait for B.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_r <= W_IDLE;
      wr_addr_r  <= 32'd0;
      wr_len_r   <= 8'd0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
    end else begin
      case (wr_state_r)
        W_IDLE: if (wr_accept_s) begin
          wr_addr_r  <= align_addr(wr_type, wr_addr);
          wr_len_r   <= (wr_type == TYPE_LINE) ? LEN_LINE : LEN_WORD;
          aw_done_r  <= 1'b0;
          w_done_r   <= 1'b0;
          wr_state_r <= W_ADDR;
        end
        W_ADDR: begin
          if (aw_hs_s) aw_done_r <= 1'b1;
          if (w_hs_s && wlast) w_done_r <= 1'b1;
          if ((aw_done_r || aw_hs_s) && (w_done_r || (w_hs_s && wlast)))
            wr_state_r <= W_RESP;
        end
        W_RESP: if (bvalid) wr_state_r <= W_IDLE;
        default: wr_state_r <= W_IDLE;
      endcase
    end
  end

  // Request acceptance is held off until the cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_r     <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      run_r     <= 1'b1;
      bus_err_r <= (rready && rvalid && (rresp != RESP_OKAY)) ||
                   (bready && bvalid && (bresp != RESP_OKAY));
    end
  end

endmodule

// File: tb/tb_axi_bridge.sv
// Directed bench for axi_bridge: line/word reads and writes, same-line hazard,
// error responses and reset in mid-burst, with hand-computed expectations.
module tb_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy, bus_err;
  logic [3:0]   arid, awid, rid, bid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_w [4];

  always #5 clk = ~clk;

  axi_bridge dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0; rd_req = 1'b0; rd_type = 3'b000; rd_addr = 32'd0;
    wr_req = 1'b0; wr_type = 3'b000; wr_addr = 32'd0; wr_wstrb = 4'd0; wr_data = 128'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'b00; bvalid = 1'b0;
    exp_w[0] = 32'h1111; exp_w[1] = 32'h2222; exp_w[2] = 32'h3333; exp_w[3] = 32'h4444;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_rd_rdy", rd_rdy, 1'b0);
    check("rst_wr_rdy", wr_rdy, 1'b0);
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready, ret_valid, bus_err}, 7'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk); #1;
    check("rel_rd_rdy", rd_rdy, 1'b1);
    check("rel_wr_rdy", wr_rdy, 1'b1);
    check("rel_addr", {araddr, awaddr}, 64'd0);
    check("rel_wdata", wdata, 32'd0);

    // line read, all slaves ready
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1000_0018;
    #1 check("rd_accept", rd_rdy, 1'b1);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    check("rd_arvalid", arvalid, 1'b1);
    check("rd_araddr", araddr, 32'h1000_0010);
    check("rd_arlen", arlen, 8'd3);
    check("rd_arsize_burst", {arsize, arburst, arid}, {3'b010, 2'b01, 4'd0});
    check("rd_busy", rd_rdy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'hA0 + i; rlast = (i == 3);
      #1;
      check("rd_ret_valid", ret_valid, 1'b1);
      check("rd_ret_data", ret_data, 32'hA0 + i);
      check("rd_ret_last", ret_last, (i == 3));
    end
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("rd_done_rdy", rd_rdy, 1'b1);
    check("rd_done_rready", {rready, ret_valid}, 2'b00);

    // line write, all ready, B delayed two cycles
    @(negedge clk);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h2000_0040; wr_wstrb = 4'd0;
    wr_data = 128'h00004444_00003333_00002222_00001111;
    #1 check("wl_accept", wr_rdy, 1'b1);
    @(negedge clk);
    wr_req = 1'b0;
    #1;
    check("wl_awvalid", awvalid, 1'b1);
    check("wl_awaddr", awaddr, 32'h2000_0040);
    check("wl_awattr", {awlen, awsize, awburst, awid}, {8'd3, 3'b010, 2'b01, 4'd1});
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin
        @(negedge clk); #1;
        check("wl_aw_dropped", awvalid, 1'b0);
      end
      check("wl_wvalid", wvalid, 1'b1);
      check("wl_wdata", wdata, exp_w[i]);
      check("wl_wlast", wlast, (i == 3));
      check("wl_wstrb", wstrb, 4'hF);
      check("wl_busy", wr_rdy, 1'b0);
    end
    @(negedge clk); #1;
    check("wl_resp_state", {wvalid, bready, wr_rdy}, 3'b010);
    @(negedge clk);
    bvalid = 1'b1; bresp = 2'b00;
    #1 check("wl_wait_b", {bready, wr_rdy}, 2'b10);
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    check("wl_done_rdy", wr_rdy, 1'b1);
    check("wl_done_bready", {bready, bus_err}, 2'b00);

    // word write with AW held off for 5 cycles
    @(negedge clk);
    awready = 1'b0;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h3000_0004; wr_wstrb = 4'b0011;
    wr_data = 128'hDEAD_BEEF;
    #1 check("ww_accept", wr_rdy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_req = 1'b0;
      if (i == 4) awready = 1'b1;
      #1 check("ww_awvalid_held", awvalid, 1'b1);
      if (i == 0) begin
        check("ww_awaddr", awaddr, 32'h3000_0004);
        check("ww_awlen", awlen, 8'd0);
        check("ww_beat", {wvalid, wlast, wstrb}, {1'b1, 1'b1, 4'b0011});
        check("ww_wdata", wdata, 32'hDEAD_BEEF);
      end
      if (i == 1) check("ww_wvalid_done", wvalid, 1'b0);
    end
    @(negedge clk);
    bvalid = 1'b1;
    #1 check("ww_resp", {awvalid, bready}, 2'b01);
    @(negedge clk);
    bvalid = 1'b0;
    #1 check("ww_done", {wr_rdy, bready}, 2'b10);

    // same-line writeback blocks the read until B; read then sees rresp error on beat 2
    @(negedge clk);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_0040; wr_data = 128'h5;
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0048;
    #1;
    check("hz_wr_accept", wr_rdy, 1'b1);
    check("hz_rd_stall0", rd_rdy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_req = 1'b0;
      #1 check("hz_rd_stall", rd_rdy, 1'b0);
    end
    @(negedge clk);
    bvalid = 1'b1;
    #1 check("hz_rd_stall_b", rd_rdy, 1'b0);
    @(negedge clk);
    bvalid = 1'b0;
    #1 check("hz_rd_release", rd_rdy, 1'b1);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    check("hz_arvalid", arvalid, 1'b1);
    check("hz_araddr", araddr, 32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'hB0 + i; rlast = (i == 3);
      rresp = (i == 1) ? 2'b10 : 2'b00;
      #1;
      check("err_ret_valid", ret_valid, 1'b1);
      check("err_ret_data", ret_data, 32'hB0 + i);
      check("err_bus_err", bus_err, (i == 2));
    end
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    #1;
    check("err_pulse_end", bus_err, 1'b0);
    check("err_rd_idle", rd_rdy, 1'b1);

    // different lines proceed in parallel; B returns SLVERR
    @(negedge clk);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_0040; wr_data = 128'h7;
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0080;
    #1 check("par_both_rdy", {rd_rdy, wr_rdy}, 2'b11);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    #1;
    check("par_both_valid", {arvalid, awvalid, wvalid}, 3'b111);
    check("par_araddr", araddr, 32'h0000_0080);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'hC0 + i; rlast = (i == 3);
      if (i == 3) begin
        bvalid = 1'b1; bresp = 2'b10;
      end
      #1 check("par_ret_data", {ret_valid, ret_data}, {1'b1, 32'hC0 + i});
      if (i == 3) check("par_bready", bready, 1'b1);
    end
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    #1;
    check("par_bresp_err", bus_err, 1'b1);
    check("par_idle", {rd_rdy, wr_rdy}, 2'b11);
    @(negedge clk); #1;
    check("par_err_pulse", bus_err, 1'b0);

    // reset during beat 2 of a line write
    @(negedge clk);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_0050; wr_data = 128'h9;
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    #1 check("mr_in_burst", wvalid, 1'b1);
    rst = 1'b0;
    #1;
    check("mr_outputs", {wvalid, awvalid, bready}, 3'b000);
    check("mr_rdy_low", {wr_rdy, rd_rdy}, 2'b00);
    @(negedge clk) rst = 1'b1;
    @(negedge clk); #1;
    check("mr_wr_rdy", wr_rdy, 1'b1);
    check("mr_idle", {wvalid, awvalid, rd_rdy}, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
